// File: rtl/register_file_mq_fifo.sv
// Multi-queue FIFO on one shared 1R1W register-file memory.
// NUM_Q = 1<<NUM_Q_BITS queues, each a fixed DEPTH = 1<<DEPTH_BITS partition
// addressed as {qid, ptr}. Registered read data with a valid pulse, per-queue
// empty/full flags and one-cycle error pulses for dropped writes and reads.
// Optional feature: define MQ_FIFO_BYPASS_EN to let a read of an empty queue
// take the same-cycle write data of that queue.
module register_file_mq_fifo #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned NUM_Q_BITS = 2,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_i,
  input  logic [NUM_Q_BITS-1:0]       wr_qid_i,
  input  logic [WIDTH-1:0]            din_i,
  input  logic                        rd_i,
  input  logic [NUM_Q_BITS-1:0]       rd_qid_i,
  output logic [WIDTH-1:0]            dout_o,
  output logic                        dout_valid_o,
  output logic [(1<<NUM_Q_BITS)-1:0]  empty_o,
  output logic [(1<<NUM_Q_BITS)-1:0]  full_o,
  output logic                        wr_err_o,
  output logic                        rd_err_o
);

  localparam int unsigned NumQ  = 1 << NUM_Q_BITS;
  localparam int unsigned Depth = 1 << DEPTH_BITS;
  localparam int unsigned AddrW = NUM_Q_BITS + DEPTH_BITS;

  logic [DEPTH_BITS:0] wptr_q [NumQ];
  logic [DEPTH_BITS:0] wptr_d [NumQ];
  logic [DEPTH_BITS:0] rptr_q [NumQ];
  logic [DEPTH_BITS:0] rptr_d [NumQ];

  logic [WIDTH-1:0] mem_q [NumQ*Depth];

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q;
  logic             wr_err_q, rd_err_q;

  logic             same_q;
  logic             wr_acc, rd_acc;
  logic             rd_bypass;
  logic [AddrW-1:0] wr_addr, rd_addr;
  logic [WIDTH-1:0] rd_data;

  // Flags straight from the pointer registers; MSB acts as the wrap bit.
  always_comb begin
    empty_o = '0;
    full_o  = '0;
    for (int unsigned q = 0; q < NumQ; q++) begin
      empty_o[q] = (wptr_q[q] == rptr_q[q]);
      full_o[q]  = (wptr_q[q][DEPTH_BITS] != rptr_q[q][DEPTH_BITS]) &&
                   (wptr_q[q][DEPTH_BITS-1:0] == rptr_q[q][DEPTH_BITS-1:0]);
    end
  end

  // Accept decisions and memory addressing.
  always_comb begin
    same_q    = (wr_qid_i == rd_qid_i);
    // A full queue still takes a write when the same cycle pops it.
    wr_acc    = wr_i && (!full_o[wr_qid_i] || (rd_i && same_q));
`ifdef MQ_FIFO_BYPASS_EN
    rd_bypass = rd_i && empty_o[rd_qid_i] && wr_acc && same_q;
`else
    rd_bypass = 1'b0;
`endif
    rd_acc    = (rd_i && !empty_o[rd_qid_i]) || rd_bypass;
    wr_addr   = {wr_qid_i, wptr_q[wr_qid_i][DEPTH_BITS-1:0]};
    rd_addr   = {rd_qid_i, rptr_q[rd_qid_i][DEPTH_BITS-1:0]};
  end

  // Read data select: memory (old data on a same-slot write), or din on bypass.
  always_comb begin
`ifdef MQ_FIFO_BYPASS_EN
    rd_data = rd_bypass ? din_i : mem_q[rd_addr];
`else
    rd_data = mem_q[rd_addr];
`endif
    dout_d  = rd_acc ? rd_data : dout_q;
  end

  // Next-state pointers: only the addressed queue(s) advance.
  always_comb begin
    for (int unsigned q = 0; q < NumQ; q++) begin
      wptr_d[q] = wptr_q[q];
      rptr_d[q] = rptr_q[q];
      if (wr_acc && (wr_qid_i == NUM_Q_BITS'(q))) begin
        wptr_d[q] = wptr_q[q] + 1'b1;
      end
      if (rd_acc && (rd_qid_i == NUM_Q_BITS'(q))) begin
        rptr_d[q] = rptr_q[q] + 1'b1;
      end
    end
  end

  // Pointer, output and error-pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned q = 0; q < NumQ; q++) begin
        wptr_q[q] <= '0;
        rptr_q[q] <= '0;
      end
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      for (int unsigned q = 0; q < NumQ; q++) begin
        wptr_q[q] <= wptr_d[q];
        rptr_q[q] <= rptr_d[q];
      end
      dout_q       <= dout_d;
      dout_valid_q <= rd_acc;
      wr_err_q     <= wr_i && !wr_acc;
      rd_err_q     <= rd_i && !rd_acc;
    end
  end

  // Memory array, intentionally not reset so it maps onto register-file RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_addr] <= din_i;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign wr_err_o     = wr_err_q;
  assign rd_err_o     = rd_err_q;

endmodule

// File: tb/tb_register_file_mq_fifo.sv
// Directed self-checking bench for register_file_mq_fifo with a per-queue
// reference model and a scoreboard of expected read data.
module tb_register_file_mq_fifo;

  logic        clk;
  logic        rstn;
  logic        wr_i;
  logic [1:0]  wr_qid_i;
  logic [63:0] din_i;
  logic        rd_i;
  logic [1:0]  rd_qid_i;
  logic [63:0] dout_o;
  logic        dout_valid_o;
  logic [3:0]  empty_o;
  logic [3:0]  full_o;
  logic        wr_err_o;
  logic        rd_err_o;

  int checks;
  int failures;

  // Reference model: circular buffer per queue.
  logic [63:0] mm [4][16];
  int          hd [4];
  int          ct [4];
  logic [63:0] sb [$];

  register_file_mq_fifo #(
    .WIDTH      (64),
    .NUM_Q_BITS (2),
    .DEPTH_BITS (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_i         (wr_i),
    .wr_qid_i     (wr_qid_i),
    .din_i        (din_i),
    .rd_i         (rd_i),
    .rd_qid_i     (rd_qid_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .wr_err_o     (wr_err_o),
    .rd_err_o     (rd_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int q = 0; q < 4; q++) begin
      hd[q] = 0;
      ct[q] = 0;
    end
    sb.delete();
  endtask

  task automatic chk_flags(input string tag);
    logic [3:0] ee;
    logic [3:0] ef;
    for (int q = 0; q < 4; q++) begin
      ee[q] = (ct[q] == 0);
      ef[q] = (ct[q] == 16);
    end
    chk({tag, ".empty"}, {60'd0, empty_o}, {60'd0, ee});
    chk({tag, ".full"}, {60'd0, full_o}, {60'd0, ef});
  endtask

  // One clock of stimulus: predict, drive, clock, then check outputs 1 ns after the edge.
  task automatic step(input string tag, input bit w, input int wq, input logic [63:0] d,
                      input bit r, input int rq);
    bit wacc;
    bit racc;
    bit popped;
    logic [63:0] e;
    wacc = w && ((ct[wq] < 16) || (r && (rq == wq)));
    racc = r && (ct[rq] > 0);
`ifdef MQ_FIFO_BYPASS_EN
    if (r && (ct[rq] == 0) && wacc && (wq == rq)) racc = 1'b1;
`endif
    wr_i     = w;
    wr_qid_i = 2'(wq);
    din_i    = d;
    rd_i     = r;
    rd_qid_i = 2'(rq);
    popped   = 1'b0;
    if (racc && (ct[rq] > 0)) begin
      sb.push_back(mm[rq][hd[rq]]);
      hd[rq] = (hd[rq] + 1) % 16;
      ct[rq]--;
      popped = 1'b1;
    end
    if (wacc) begin
      mm[wq][(hd[wq] + ct[wq]) % 16] = d;
      ct[wq]++;
    end
    if (racc && !popped) begin
      sb.push_back(mm[rq][hd[rq]]);
      hd[rq] = (hd[rq] + 1) % 16;
      ct[rq]--;
    end
    @(posedge clk);
    #1;
    wr_i = 1'b0;
    rd_i = 1'b0;
    chk({tag, ".dout_valid"}, {63'd0, dout_valid_o}, {63'd0, racc});
    chk({tag, ".wr_err"}, {63'd0, wr_err_o}, {63'd0, w && !wacc});
    chk({tag, ".rd_err"}, {63'd0, rd_err_o}, {63'd0, r && !racc});
    if (racc) begin
      e = sb.pop_front();
      chk({tag, ".dout"}, dout_o, e);
    end
    chk_flags(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_clear();
    wr_i     = 1'b0;
    wr_qid_i = '0;
    din_i    = '0;
    rd_i     = 1'b0;
    rd_qid_i = '0;
    rstn     = 1'b0;

    // 1: reset state
    #2;
    chk("rst.empty", {60'd0, empty_o}, 64'hF);
    chk("rst.full", {60'd0, full_o}, 64'h0);
    chk("rst.dout_valid", {63'd0, dout_valid_o}, 64'h0);
    chk("rst.dout", dout_o, 64'h0);
    chk("rst.wr_err", {63'd0, wr_err_o}, 64'h0);
    chk("rst.rd_err", {63'd0, rd_err_o}, 64'h0);
    #10;
    rstn = 1'b1;

    // 2: fill q2, overflow, drain in order
    for (int i = 0; i < 16; i++) step("fill_q2", 1'b1, 2, 64'h100 + 64'(i), 1'b0, 0);
    step("ovf_q2", 1'b1, 2, 64'hBAD, 1'b0, 0);
    step("idle_q2", 1'b0, 0, 64'h0, 1'b0, 0);
    for (int i = 0; i < 16; i++) step("drain_q2", 1'b0, 0, 64'h0, 1'b1, 2);
    step("under_q2", 1'b0, 0, 64'h0, 1'b1, 2);

    // 3: interleaved queues
    step("il_w0", 1'b1, 0, 64'hA, 1'b0, 0);
    step("il_w1", 1'b1, 1, 64'hB, 1'b0, 0);
    step("il_w3", 1'b1, 3, 64'hC, 1'b0, 0);
    step("il_r3", 1'b0, 0, 64'h0, 1'b1, 3);
    step("il_r1", 1'b0, 0, 64'h0, 1'b1, 1);
    step("il_r0", 1'b0, 0, 64'h0, 1'b1, 0);

    // 4: full q1 with simultaneous read/write
    for (int i = 0; i < 16; i++) step("fill_q1", 1'b1, 1, 64'h200 + 64'(i), 1'b0, 0);
    step("full_rw_q1", 1'b1, 1, 64'hDEAD, 1'b1, 1);
    for (int i = 0; i < 16; i++) step("drain_q1", 1'b0, 0, 64'h0, 1'b1, 1);

    // 5: empty q0 with simultaneous read/write
    step("empty_rw_q0", 1'b1, 0, 64'h55, 1'b1, 0);
    step("after_q0", 1'b0, 0, 64'h0, 1'b1, 0);

    // 6: pointer wrap on q3 with concurrent traffic on q2
    step("wrap_pre", 1'b1, 3, 64'h3000, 1'b0, 0);
    for (int i = 1; i <= 40; i++) step("wrap_rw", 1'b1, 3, 64'h3000 + 64'(i), 1'b1, 3);
    step("wrap_x", 1'b1, 2, 64'h777, 1'b1, 3);
    step("wrap_x2", 1'b0, 0, 64'h0, 1'b1, 2);

    // Reset mid-stream with a read in flight
    step("pre_rst_w0", 1'b1, 0, 64'h11, 1'b0, 0);
    step("pre_rst_w3", 1'b1, 3, 64'h33, 1'b0, 0);
    rd_i     = 1'b1;
    rd_qid_i = 2'd3;
    #2;
    rstn = 1'b0;
    #1;
    rd_i = 1'b0;
    model_clear();
    chk("mrst.empty", {60'd0, empty_o}, 64'hF);
    chk("mrst.full", {60'd0, full_o}, 64'h0);
    chk("mrst.dout_valid", {63'd0, dout_valid_o}, 64'h0);
    chk("mrst.dout", dout_o, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    #6;
    step("post_rst_idle", 1'b0, 0, 64'h0, 1'b0, 0);
    step("post_rst_rd", 1'b0, 0, 64'h0, 1'b1, 3);
    step("post_rst_w", 1'b1, 3, 64'h99, 1'b0, 0);
    step("post_rst_r", 1'b0, 0, 64'h0, 1'b1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
